// File: rtl/dlfi_pkg.sv
// Shared lane definitions for the adder-tree data path: lane width, the sign-extension
// helper and the flat-vector lane-select macro.
`ifndef DLFI_PKG_SV
`define DLFI_PKG_SV
`define DLFI_LANE_SEL(vec, i) vec[(i)*dlfi_pkg::LANE_W +: dlfi_pkg::LANE_W]

package dlfi_pkg;
  localparam int LANE_W = 32;

  // Sign-extend the low 'width' bits of data to a full lane.
  function automatic logic [LANE_W-1:0] sext_lane(input logic [LANE_W-1:0] data,
                                                  input int width);
    logic signed [LANE_W-1:0] shifted;
    shifted = $signed(data << (LANE_W - width));
    return shifted >>> (LANE_W - width);
  endfunction
endpackage
`endif

// File: rtl/psum_vector_packer_if.sv
// Product stream in, packed lane vector out. The master modport is the environment
// (product producer plus adder tree); the slave modport is the packer itself.
interface psum_vector_packer_if
  import dlfi_pkg::*;
#(
  parameter int DATA_BITWIDTH   = 8,
  parameter int BREADTH_OF_TREE = 32
);
  localparam int LANES_W = $clog2(BREADTH_OF_TREE) + 1;

  // valid/ready: a beat transfers on a rising edge where valid && ready; once valid is
  // raised the sender holds valid and payload stable until that edge.
  logic                                s_valid;
  logic                                s_ready;
  logic [DATA_BITWIDTH-1:0]            s_data;
  logic                                s_last;
  logic                                m_valid;
  logic                                m_ready;
  logic [LANE_W*BREADTH_OF_TREE-1:0]   m_data;
  logic [LANES_W-1:0]                  m_lanes;

  modport master (output s_valid, s_data, s_last, m_ready,
                  input  s_ready, m_valid, m_data, m_lanes);
  modport slave  (input  s_valid, s_data, s_last, m_ready,
                  output s_ready, m_valid, m_data, m_lanes);
endinterface

// File: rtl/psum_vector_packer_bank.sv
// One ping-pong bank: BREADTH lanes of LANE_W bits with single-lane write,
// one-cycle whole-bank clear and flat read-out.
module psum_bank
  import dlfi_pkg::*;
#(
  parameter int BREADTH = 32,
  parameter int IDX_W   = $clog2(BREADTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic [IDX_W-1:0]          idx_i,
  input  logic [LANE_W-1:0]         wdata_i,
  input  logic                      clr_i,
  output logic [LANE_W*BREADTH-1:0] rdata_o
);
  logic [LANE_W-1:0] lane_q [BREADTH];

  // A full bank is never written, so clear and write never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BREADTH; i++) lane_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < BREADTH; i++) lane_q[i] <= '0;
    end else if (we_i) begin
      lane_q[idx_i] <= wdata_i;
    end
  end

  for (genvar g = 0; g < BREADTH; g++) begin : g_rd
    assign `DLFI_LANE_SEL(rdata_o, g) = lane_q[g];
  end
endmodule

// File: rtl/psum_vector_packer.sv
// Packs a stream of signed products into BREADTH-lane sign-extended vectors for the
// adder tree, using two banks so one fills while the other waits to be taken.
module psum_vector_packer
  import dlfi_pkg::*;
#(
  parameter int DATA_BITWIDTH   = 8,
  parameter int BREADTH_OF_TREE = 32
) (
  input logic              clk,
  input logic              rst,
  psum_vector_packer_if.slave bus
);
  localparam int IDX_W   = $clog2(BREADTH_OF_TREE);
  localparam int LANES_W = IDX_W + 1;
  localparam int VEC_W   = LANE_W * BREADTH_OF_TREE;

  if (BREADTH_OF_TREE < 2 || (BREADTH_OF_TREE & (BREADTH_OF_TREE - 1)) != 0) begin : g_bad_breadth
    $error("psum_vector_packer: BREADTH_OF_TREE must be a power of two and >= 2");
  end
  if (DATA_BITWIDTH < 1 || DATA_BITWIDTH > LANE_W) begin : g_bad_width
    $error("psum_vector_packer: DATA_BITWIDTH must be in 1..LANE_W");
  end

  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [1:0]              full_q, full_d;
  logic [1:0][LANES_W-1:0] lanes_q, lanes_d;
  logic [1:0][VEC_W-1:0]   bank_data;

  logic              accept, commit, release_v;
  logic [LANE_W-1:0] lane_wdata;

  assign accept     = bus.s_valid && !full_q[wr_bank_q];
  assign commit     = accept && (bus.s_last || cnt_q == IDX_W'(BREADTH_OF_TREE - 1));
  assign release_v  = full_q[rd_bank_q] && bus.m_ready;
  assign lane_wdata = sext_lane(LANE_W'(bus.s_data), DATA_BITWIDTH);

  for (genvar g = 0; g < 2; g++) begin : g_bank
    psum_bank #(.BREADTH(BREADTH_OF_TREE)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we_i    (accept && (wr_bank_q == 1'(g))),
      .idx_i   (cnt_q),
      .wdata_i (lane_wdata),
      .clr_i   (release_v && (rd_bank_q == 1'(g))),
      .rdata_o (bank_data[g])
    );
  end

  // Commit and release touch different banks, so both updates apply on the same edge.
  always_comb begin
    cnt_d     = cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    lanes_d   = lanes_q;
    if (accept) cnt_d = cnt_q + IDX_W'(1);
    if (commit) begin
      full_d[wr_bank_q]  = 1'b1;
      lanes_d[wr_bank_q] = LANES_W'(cnt_q) + LANES_W'(1);
      cnt_d              = '0;
      wr_bank_d          = ~wr_bank_q;
    end
    if (release_v) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      lanes_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      lanes_q   <= lanes_d;
    end
  end

  assign bus.s_ready = !full_q[wr_bank_q];
  assign bus.m_valid = full_q[rd_bank_q];
  assign bus.m_data  = full_q[rd_bank_q] ? bank_data[rd_bank_q] : '0;
  assign bus.m_lanes = full_q[rd_bank_q] ? lanes_q[rd_bank_q] : '0;
endmodule

// File: tb/tb_psum_vector_packer.sv
// Bench for psum_vector_packer: directed scenarios on a 4-lane instance and a long
// random valid/ready run on a 32-lane instance, both checked against queued vectors.
module tb_psum_vector_packer;
  import dlfi_pkg::*;

  localparam int DW = 8;
  localparam int BA = 4;
  localparam int BB = 32;
  localparam int WA = BA * 32;
  localparam int WB = BB * 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit done_a = 1'b0;
  bit done_b = 1'b0;

  psum_vector_packer_if #(.DATA_BITWIDTH(DW), .BREADTH_OF_TREE(BA)) ifa ();
  psum_vector_packer_if #(.DATA_BITWIDTH(DW), .BREADTH_OF_TREE(BB)) ifb ();

  psum_vector_packer #(.DATA_BITWIDTH(DW), .BREADTH_OF_TREE(BA)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa));
  psum_vector_packer #(.DATA_BITWIDTH(DW), .BREADTH_OF_TREE(BB)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb));

  // ---------------- scoreboard ----------------
  logic [WA-1:0] exp_a_q[$];
  int            lanes_a_q[$];
  int            cur_a[$];
  logic [WB-1:0] exp_b_q[$];
  int            lanes_b_q[$];
  int            cur_b[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [WB-1:0] act,
                           input logic [WB-1:0] exp, input int n);
    bit shown;
    checks++;
    if (act !== exp) begin
      failures++;
      shown = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (!shown && act[i*32 +: 32] !== exp[i*32 +: 32]) begin
          $display("FAIL %s lane=%0d actual=%h required=%h", name, i,
                   act[i*32 +: 32], exp[i*32 +: 32]);
          shown = 1'b1;
        end
      end
      if (!shown) $display("FAIL %s actual and required vectors differ", name);
    end
  endtask

  // Reference: products collect into a list; a vector closes at BREADTH items or on last.
  task automatic model_a(input logic [DW-1:0] d, input logic last);
    logic [WA-1:0] v;
    cur_a.push_back(int'($signed(d)));
    if (cur_a.size() == BA || last) begin
      v = '0;
      foreach (cur_a[i]) v[i*32 +: 32] = cur_a[i];
      exp_a_q.push_back(v);
      lanes_a_q.push_back(cur_a.size());
      cur_a.delete();
    end
  endtask

  task automatic model_b(input logic [DW-1:0] d, input logic last);
    logic [WB-1:0] v;
    cur_b.push_back(int'($signed(d)));
    if (cur_b.size() == BB || last) begin
      v = '0;
      foreach (cur_b[i]) v[i*32 +: 32] = cur_b[i];
      exp_b_q.push_back(v);
      lanes_b_q.push_back(cur_b.size());
      cur_b.delete();
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst_a) begin
      if (ifa.m_valid) begin
        if (exp_a_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_unexpected_vector actual=%h required=none", ifa.m_data);
        end else begin
          check_vec("a_m_data", WB'(ifa.m_data), WB'(exp_a_q[0]), BA);
          check("a_m_lanes", ifa.m_lanes, lanes_a_q[0]);
          if (ifa.m_ready) begin
            void'(exp_a_q.pop_front());
            void'(lanes_a_q.pop_front());
          end
        end
      end else begin
        check("a_idle_zero", {|ifa.m_data, |ifa.m_lanes}, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      if (ifb.m_valid) begin
        if (exp_b_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected_vector actual_lanes=%0d required=none", ifb.m_lanes);
        end else begin
          check_vec("b_m_data", ifb.m_data, exp_b_q[0], BB);
          check("b_m_lanes", ifb.m_lanes, lanes_b_q[0]);
          if (ifb.m_ready) begin
            void'(exp_b_q.pop_front());
            void'(lanes_b_q.pop_front());
          end
        end
      end else begin
        check("b_idle_zero", {|ifb.m_data, |ifb.m_lanes}, 0);
      end
    end
  end

  // ---------------- driver tasks (instance A) ----------------
  task automatic send_a(input logic [DW-1:0] d, input logic last);
    int waited;
    bit done;
    waited = 0;
    done = 1'b0;
    ifa.s_valid = 1'b1;
    ifa.s_data  = d;
    ifa.s_last  = last;
    while (!done) begin
      check("a_s_ready", ifa.s_ready, exp_a_q.size() < 2);
      if (ifa.s_ready) begin
        model_a(d, last);
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (!done && ++waited > 200) begin
        checks++; failures++;
        $display("FAIL a_send_timeout actual=stalled required=accept");
        done = 1'b1;
      end
    end
    ifa.s_valid = 1'b0;
    ifa.s_last  = 1'b0;
  endtask

  task automatic release_a();
    ifa.m_ready = 1'b1;
    @(posedge clk); #1;
    ifa.m_ready = 1'b0;
  endtask

  task automatic drain_a(input int n);
    ifa.m_ready = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    ifa.m_ready = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_s_ready"}, ifa.s_ready, 1);
    check({tag, "_m_valid"}, ifa.m_valid, 0);
    check({tag, "_m_data"}, |ifa.m_data, 0);
    check({tag, "_m_lanes"}, ifa.m_lanes, 0);
  endtask

  task automatic flush_a();
    cur_a.delete();
    exp_a_q.delete();
    lanes_a_q.delete();
  endtask

  // ---------------- directed scenarios on instance A ----------------
  initial begin
    int t0;
    ifa.s_valid = 1'b0;
    ifa.s_data  = '0;
    ifa.s_last  = 1'b0;
    ifa.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_a("rst0");
    rst_a = 1'b0;
    @(posedge clk); #1;

    // Sign extension of boundary values and one-cycle commit latency.
    send_a(8'd1, 1'b0);
    send_a(8'hFF, 1'b0);
    send_a(8'd127, 1'b0);
    send_a(8'h80, 1'b0);
    check("t1_m_valid", ifa.m_valid, 1);
    check_vec("t1_m_data", WB'(ifa.m_data),
              WB'(128'hFFFFFF80_0000007F_FFFFFFFF_00000001), BA);
    check("t1_m_lanes", ifa.m_lanes, 4);
    release_a();
    check("t1_one_cycle", ifa.m_valid, 0);

    // Early close with s_last; next vector restarts at lane 0.
    send_a(8'd5, 1'b0);
    send_a(8'd6, 1'b1);
    check_vec("t2_m_data", WB'(ifa.m_data),
              WB'(128'h00000000_00000000_00000006_00000005), BA);
    check("t2_m_lanes", ifa.m_lanes, 2);
    release_a();
    for (int i = 0; i < 4; i++) send_a(8'(7 + i), 1'b0);
    check("t2_next_lane0", ifa.m_data[31:0], 7);
    drain_a(2);

    // Both banks full, then one release frees a bank for the next products.
    for (int i = 1; i <= 8; i++) send_a(8'(i * 3), 1'b0);
    check("t3_s_ready_low", ifa.s_ready, 0);
    fork
      for (int i = 9; i <= 12; i++) send_a(8'(i * 3), 1'b0);
      begin
        repeat (3) begin @(posedge clk); #1; end
        release_a();
        check("t3_s_ready_after_release", ifa.s_ready, 1);
      end
    join
    drain_a(6);

    // Continuous stream with a release every fourth edge at each phase.
    for (int ph = 0; ph < 4; ph++) begin
      t0 = cyc;
      fork
        begin
          for (int k = 0; k < 16; k++) send_a(8'($urandom), 1'b0);
          check("t4_throughput", cyc - t0, 16);
        end
        begin
          for (int c = 0; c < 40; c++) begin
            ifa.m_ready = (c % 4 == ph);
            @(posedge clk); #1;
          end
          ifa.m_ready = 1'b0;
        end
      join
      drain_a(4);
    end

    // Reset mid-vector, then reset while a vector is presented.
    send_a(8'd21, 1'b0);
    send_a(8'd22, 1'b0);
    rst_a = 1'b1;
    #2;
    check_reset_a("t5a");
    flush_a();
    @(posedge clk); #1;
    rst_a = 1'b0;
    for (int i = 0; i < 4; i++) send_a(8'(40 + i), 1'b0);
    check("t5_m_valid_before", ifa.m_valid, 1);
    rst_a = 1'b1;
    #2;
    check_reset_a("t5b");
    flush_a();
    @(posedge clk); #1;
    rst_a = 1'b0;
    send_a(8'hF0, 1'b0);
    send_a(8'd3, 1'b0);
    send_a(8'h81, 1'b0);
    send_a(8'd99, 1'b0);
    check_vec("t5_post_reset", WB'(ifa.m_data),
              WB'(128'h00000063_FFFFFF81_00000003_FFFFFFF0), BA);
    drain_a(3);
    done_a = 1'b1;
  end

  // ---------------- random traffic on instance B ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      ifb.m_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    int sent;
    int stall;
    bit acc;
    sent = 0;
    stall = 0;
    ifb.s_valid = 1'b0;
    ifb.s_data  = '0;
    ifb.s_last  = 1'b0;
    ifb.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b0;
    while (sent < 10000 && stall <= 500) begin
      if (!ifb.s_valid) begin
        ifb.s_valid = ($urandom_range(0, 3) != 0);
        ifb.s_data  = 8'($urandom);
        ifb.s_last  = ($urandom_range(0, 15) == 0);
      end
      check("b_s_ready", ifb.s_ready, exp_b_q.size() < 2);
      acc = ifb.s_valid && ifb.s_ready;
      if (acc) begin
        model_b(ifb.s_data, ifb.s_last);
        sent++;
        stall = 0;
      end else if (ifb.s_valid) begin
        stall++;
      end
      @(posedge clk); #1;
      if (acc) ifb.s_valid = 1'b0;
    end
    if (stall > 500) begin
      checks++; failures++;
      $display("FAIL b_stall_timeout actual=stalled required=accept");
    end
    ifb.s_valid = 1'b0;
    repeat (200) @(posedge clk);
    done_b = 1'b1;
  end

  // ---------------- final report ----------------
  initial begin
    int w;
    w = 0;
    while (!(done_a && done_b) && w < 90000) begin
      @(posedge clk);
      w++;
    end
    checks++;
    if (!(done_a && done_b)) begin
      failures++;
      $display("FAIL run_timeout actual=%0d%0d required=11", done_a, done_b);
    end
    @(posedge clk); #1;
    check("a_drained", exp_a_q.size(), 0);
    check("b_drained", exp_b_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
